// File: rtl/memory_port_ctrl_pkg.sv
// Shared definitions for the storage-port initiator: default widths,
// storage depth and the controller state encoding.
package memory_port_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

  // Explicit encodings keep the state values identical to the legacy design.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_SETUP  = 3'd1,
    ST_W_STROBE = 3'd2,
    ST_W_HOLD   = 3'd3,
    ST_R_SAMPLE = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

endpackage

// File: rtl/memory_port_ctrl.sv
// Initiator for the addressable storage block: single read/write requests,
// a registered store strobe with setup/hold margins, read capture with
// response backpressure, and an in-order scan of every location.
module memory_port_ctrl
  import memory_port_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned STORE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              scan_start,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_store,
  output logic [ADDR_W-1:0] mem_adder,
  input  logic [DATA_W-1:0] mem_memory
);

  localparam int unsigned       CNT_W     = (STORE_CYCLES > 1) ? $clog2(STORE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(STORE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               scan_q, scan_d;
  logic               mem_store_q, mem_store_d;
  logic [ADDR_W-1:0]  mem_adder_q, mem_adder_d;
  logic [DATA_W-1:0]  mem_data_q, mem_data_d;
  logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_last_q, rsp_last_d;

  // Gated by rst_n so the request side looks closed while reset is held.
  assign req_ready = rst_n && (state_q == ST_IDLE) && !scan_start;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign mem_store = mem_store_q;
  assign mem_adder = mem_adder_q;
  assign mem_data  = mem_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;

  // Next-state, port and response register computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scan_d      = scan_q;
    mem_adder_d = mem_adder_q;
    mem_data_d  = mem_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          mem_adder_d = '0;
          scan_d      = 1'b1;
          state_d     = ST_R_SAMPLE;
        end else if (req_valid && req_ready) begin
          mem_adder_d = req_addr;
          scan_d      = 1'b0;
          if (req_write) begin
            mem_data_d = req_wdata;
            state_d    = ST_W_SETUP;
          end else begin
            state_d = ST_R_SAMPLE;
          end
        end
      end
      ST_W_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_W_STROBE;
      end
      ST_W_STROBE: begin
        if (cnt_q == '0) state_d = ST_W_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_W_HOLD: state_d = ST_IDLE;
      ST_R_SAMPLE: begin
        rsp_data_d = mem_memory;
        rsp_addr_d = mem_adder_q;
        rsp_last_d = !scan_q || (mem_adder_q == LAST_ADDR);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (scan_q && (mem_adder_q != LAST_ADDR)) begin
            mem_adder_d = mem_adder_q + ADDR_W'(1);
            state_d     = ST_R_SAMPLE;
          end else begin
            scan_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Store strobe is registered from the next state so it is glitch-free
    // and exactly aligned with the W_STROBE cycles.
    mem_store_d = (state_d == ST_W_STROBE);
  end

  // State and output registers; reset clears everything, including a live strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      scan_q      <= 1'b0;
      mem_store_q <= 1'b0;
      mem_adder_q <= '0;
      mem_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scan_q      <= scan_d;
      mem_store_q <= mem_store_d;
      mem_adder_q <= mem_adder_d;
      mem_data_q  <= mem_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

endmodule

// File: tb/tb_memory_port_ctrl.sv
// Scoreboard bench for memory_port_ctrl: a behavioural storage array drives
// mem_memory, a reference array predicts read/scan responses, and a monitor
// compares every presented response against the queue head.
module tb_memory_port_ctrl;

  localparam int S1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_write = 1'b0, scan_start = 1'b0, rsp_ready = 1'b1;
  logic [1:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_last, busy, mem_store;
  logic [1:0] rsp_addr, mem_adder;
  logic [7:0] rsp_data, mem_data, mem_memory;

  logic       b_req_valid = 1'b0, b_req_write = 1'b0;
  logic [1:0] b_req_addr = '0;
  logic [7:0] b_req_wdata = '0;
  logic       b_req_ready, b_rsp_valid, b_rsp_last, b_busy, b_mem_store;
  logic [1:0] b_rsp_addr, b_mem_adder;
  logic [7:0] b_rsp_data, b_mem_data, b_mem_memory;

  memory_port_ctrl #(.DATA_W(8), .ADDR_W(2), .STORE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .scan_start(scan_start), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
    .mem_data(mem_data), .mem_store(mem_store), .mem_adder(mem_adder),
    .mem_memory(mem_memory));

  memory_port_ctrl #(.DATA_W(8), .ADDR_W(2), .STORE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .scan_start(1'b0), .rsp_valid(b_rsp_valid), .rsp_ready(1'b1),
    .rsp_addr(b_rsp_addr), .rsp_data(b_rsp_data), .rsp_last(b_rsp_last), .busy(b_busy),
    .mem_data(b_mem_data), .mem_store(b_mem_store), .mem_adder(b_mem_adder),
    .mem_memory(b_mem_memory));

  // Storage blocks: write on a clock edge while store is high, asynchronous read.
  logic [7:0] st1 [4] = '{default: 8'h00};
  logic [7:0] st3 [4] = '{default: 8'h00};
  always @(posedge clk) if (mem_store) st1[mem_adder] <= mem_data;
  always @(posedge clk) if (b_mem_store) st3[b_mem_adder] <= b_mem_data;
  assign mem_memory   = st1[mem_adder];
  assign b_mem_memory = st3[b_mem_adder];

  typedef struct { logic [1:0] a; logic [7:0] d; logic l; } exp_t;
  exp_t       sbq [$];
  logic [7:0] ref_mem [4] = '{default: 8'h00};

  int total = 0, bad = 0, cyc = 0, rmode = 2;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response consumer: 0 random, 1 toggling, 2 always ready.
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0:       rsp_ready = 1'($urandom_range(0, 1));
      1:       rsp_ready = ~rsp_ready;
      default: rsp_ready = 1'b1;
    endcase
  end

  // Monitor: every cycle a response is offered it must equal the queue head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got addr %0h data %0h, required none", rsp_addr, rsp_data);
      end else begin
        chk("rsp_addr", rsp_addr, sbq[0].a);
        chk("rsp_data", rsp_data, sbq[0].d);
        chk("rsp_last", rsp_last, sbq[0].l);
        if (rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic push_scan();
    for (int i = 0; i < 4; i++) sbq.push_back('{a: 2'(i), d: ref_mem[i], l: (i == 3)});
  endtask

  task automatic issue(input bit scan, input bit req, input bit w,
                       input logic [1:0] a, input logic [7:0] d);
    int k;
    int n;
    @(posedge clk); #1;
    scan_start = scan; req_valid = req; req_write = w; req_addr = a; req_wdata = d;
    if (scan) begin
      n = 0;
      while (1) begin
        @(negedge clk);
        if (!busy) break;
        if (++n > 500) begin chk("scan_wait_timeout", 1, 0); break; end
      end
      chk("rdy_low_on_scan", req_ready, 0);
      push_scan();
      @(posedge clk); #1;
      scan_start = 1'b0;
      if (!req) begin
        n = 0;
        while (sbq.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
        chk("scan_drain", sbq.size(), 0);
        chk("busy_after_scan", busy, 0);
        return;
      end
    end
    n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      if (++n > 500) begin
        chk("accept_timeout", 0, 1);
        @(posedge clk); #1; req_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (scan) chk("req_after_scan", sbq.size(), 0);
    k = cyc;
    if (w) ref_mem[a] = d;
    else   sbq.push_back('{a: a, d: ref_mem[a], l: 1'b1});
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (w) begin
      for (int i = 0; i < S1 + 2; i++) begin
        @(negedge clk);
        chk("wr_store", mem_store, (i >= 1 && i <= S1));
        chk("wr_adder", mem_adder, a);
        chk("wr_data", mem_data, d);
        chk("wr_ready_low", req_ready, 0);
      end
      @(negedge clk);
      chk("wr_done_ready", req_ready, 1);
    end else begin
      n = 0;
      while (1) begin
        @(negedge clk);
        if (rsp_valid || ++n > 50) break;
      end
      chk("rd_latency", cyc - k, 2);
    end
  endtask

  initial begin
    int st_cnt;
    int bz_cnt;
    int n;
    #3;
    chk("rst_outputs", {req_ready, rsp_valid, rsp_last, busy, mem_store, mem_adder,
                        mem_data, rsp_addr, rsp_data}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", req_ready, 1);

    // STORE_CYCLES=3 instance: pulse width, occupancy, readback.
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 2'd3; b_req_wdata = 8'hFF;
    @(negedge clk) chk("b_ready", b_req_ready, 1);
    @(posedge clk); #1 b_req_valid = 1'b0;
    st_cnt = 0; bz_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!b_busy) break;
      bz_cnt++;
      if (b_mem_store) st_cnt++;
    end
    chk("b_store_width", st_cnt, 3);
    chk("b_busy_cycles", bz_cnt, 5);
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 2'd3;
    @(posedge clk); #1 b_req_valid = 1'b0;
    n = 0;
    while (!b_rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("b_rd_data", b_rsp_data, 8'hFF);
    chk("b_rd_addr", b_rsp_addr, 3);
    chk("b_rd_last", b_rsp_last, 1);

    // Directed writes then single read.
    issue(0, 1, 1, 2'd2, 8'hA5);
    issue(0, 1, 1, 2'd0, 8'h11);
    issue(0, 1, 1, 2'd1, 8'h22);
    issue(0, 1, 1, 2'd2, 8'h33);
    issue(0, 1, 1, 2'd3, 8'h44);
    issue(0, 1, 0, 2'd1, 8'h00);

    // Scan under toggling backpressure, then scan racing a request.
    rmode = 1;
    issue(1, 0, 0, 2'd0, 8'h00);
    issue(1, 1, 0, 2'd2, 8'h00);

    // Reset during the store strobe.
    rmode = 2;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd1; req_wdata = 8'h5A;
    @(negedge clk) chk("rst_wr_ready", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #2;
    chk("strobe_before_rst", mem_store, 1);
    rst_n = 1'b0;
    #1;
    chk("strobe_async_clear", mem_store, 0);
    chk("rst_mid_outputs", {req_ready, rsp_valid, busy, mem_adder, mem_data, rsp_data}, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_after_rst2", req_ready, 1);

    // Randomized traffic against the reference array.
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      rmode = $urandom_range(0, 2);
      if (r < 5)      issue(0, 1, 1, 2'($urandom), 8'($urandom));
      else if (r < 9) issue(0, 1, 0, 2'($urandom), 8'h00);
      else            issue(1, 0, 0, 2'd0, 8'h00);
    end
    rmode = 2;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("final_drain", sbq.size(), 0);
    @(posedge clk); #1;
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_port_ctrl.md
Name: memory_port_ctrl

Overview:
- Sequential initiator for the 4 x 8-bit addressable storage block.
- The storage port is data / store / adder in and memory out. This block is the controlling end of that port.
- Accepts single read and write requests over a valid/ready handshake and generates a glitch-free store pulse with setup and hold margins.
- Captures read data and offers a scan mode that streams every location out in address order. It sits between user logic (switch/button front end or test sequencer) and the storage.

Parameters:
- DATA_W, 8, width of one storage word
- ADDR_W, 2, address width; depth = 2**ADDR_W
- STORE_CYCLES, 1, width of the store pulse in clocks (>=1)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- scan_start  in  1  pulse: read all locations 0..depth-1
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts the response
- rsp_addr  out  ADDR_W  address of the returned data
- rsp_data  out  DATA_W  returned data
- rsp_last  out  1  final response of a scan (always 1 for a single read)
- busy  out  1  state != IDLE
- mem_data  out  DATA_W  to storage data input
- mem_store  out  1  to storage store input
- mem_adder  out  ADDR_W  to storage address input
- mem_memory  in  DATA_W  from storage memory output

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - All outputs 0; req_ready 0 during reset, 1 after reset in IDLE.
  - mem_store is forced 0 asynchronously on reset, including mid-pulse.
  - The FSM enters IDLE; the scan counter and the address/data registers clear.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_SAMPLE, RESP.
- All mem_* outputs come straight from registers; no combinational path from inputs to mem_*.
- req_ready = (state==IDLE) && !scan_start.
- scan_start has priority over a simultaneous req_valid. scan_start is ignored unless in IDLE.
- IDLE:
  - On scan_start: scan counter <= 0; mem_adder <= 0; go to R_SAMPLE; scan flag set.
  - Else, on req_valid && req_ready: latch addr/data into mem_adder/mem_data.
    - Write goes to W_SETUP.
    - Read goes to R_SAMPLE.
- W_SETUP: one cycle; mem_store = 0; address and data stable.
- W_STROBE: mem_store = 1 for exactly STORE_CYCLES cycles (down-counter).
- W_HOLD: one cycle; mem_store = 0; address and data unchanged; then IDLE.
- Write cost: a write occupies 2+STORE_CYCLES cycles after acceptance and produces no response.
- R_SAMPLE: one cycle; mem_memory is registered into rsp_data at the end of it; rsp_addr <= mem_adder; then RESP.
- Read latency: rsp_valid rises 2 clocks after the accepting edge.
- RESP:
  - rsp_valid = 1. rsp_data, rsp_addr and rsp_last are held stable until rsp_valid && rsp_ready.
  - rsp_last = 1 for a single read, or for a scan when rsp_addr == depth-1.
  - On handshake:
    - Scan with more addresses: mem_adder <= mem_adder+1, go to R_SAMPLE.
    - Otherwise: go to IDLE and clear the scan flag.
- Backpressure: rsp_ready may be low indefinitely; no data is lost.
- Back-to-back: a new request can be accepted the cycle after returning to IDLE.
- No bypass: a read issued directly after a write returns the newly written value.
- mem_data is not modified during reads.
- Wrap-around: the scan terminates at depth-1 and never wraps to 0.
- A mid-operation reset aborts the transaction; storage contents are unspecified/owned by the storage block.

Decomposition:
- Shared package: state enum (IDLE..RESP), DATA_W/ADDR_W defaults, DEPTH constant.
- No sub-module is needed; the single FSM plus counters fits in one module.
- Optional sub-module store_pulse_gen (down-counter producing mem_store) if it is reused elsewhere.

Test Plan:
- Write addr 2, data 0xA5 with STORE_CYCLES=1 -> mem_store high exactly 1 cycle, mem_adder=2 and mem_data=0xA5 stable one cycle before and after; req_ready low for 3 cycles.
- Write 0x11,0x22,0x33,0x44 to addr 0..3, then read addr 1 -> rsp_valid 2 cycles after accept, rsp_data=0x22, rsp_addr=1, rsp_last=1.
- scan_start after the above, rsp_ready toggling 1/0 -> four responses 0x11,0x22,0x33,0x44 in order; rsp_last only on addr 3; data held while rsp_ready=0; busy falls after the 4th handshake.
- scan_start and req_valid high in the same IDLE cycle -> scan runs; req_ready=0; the request is accepted only after the scan finishes.
- Assert rst_n=0 during W_STROBE -> mem_store drops to 0 without waiting for clk; all outputs 0; after release req_ready=1.
- STORE_CYCLES=3, write addr 3 data 0xFF -> mem_store high exactly 3 cycles; total busy 5 cycles; readback returns 0xFF.
